fp_normalize_round: RTL and testbench



---
 rtl/fp_pkg.sv | 26 ++
 rtl/fp_normalize_round_lod.sv | 21 ++
 rtl/fp_normalize_round.sv | 178 +++++++++++++++++
 tb/tb_fp_normalize_round.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants and types for the normalize/round stage of the FP datapath.
package fp_pkg;

   // Bit positions inside the 3-bit flag word {overflow, underflow, inexact}.
   localparam int FLAG_OVF = 2;
   localparam int FLAG_UDF = 1;
   localparam int FLAG_INX = 0;

   // Exponent bias for a packed exponent of the given width.
   function automatic int fp_bias(input int exp_width);
      return (1 << (exp_width - 1)) - 1;
   endfunction

   // Smallest biased exponent that no longer encodes a finite number.
   function automatic int fp_exp_limit(input int exp_width);
      return (1 << exp_width) - 1;
   endfunction

   // Exception flags, laid out to match the out_flags bit order.
   typedef struct packed {
      logic ovf;
      logic udf;
      logic inx;
   } fp_flags_t;

endpackage

// File: rtl/fp_normalize_round_lod.sv
// Leading-one detector: position of the most significant set bit.
module leading_one_detector #(
   parameter  int WIDTH = 27,
   localparam int PW    = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] i_vec,
   output logic [PW-1:0]    o_pos,
   output logic             o_has_one
);

   // Scan upward so the highest set bit wins.
   always_comb begin
      o_pos = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i_vec[i]) o_pos = PW'(i);
      end
   end

   assign o_has_one = |i_vec;

endmodule

// File: rtl/fp_normalize_round.sv
// Normalize, round-to-nearest-even and pack stage. Stage 1 registers the raw
// result with its leading-one position; stage 2 shifts, rounds and registers
// the packed word straight into the outputs.
module fp_normalize_round
   import fp_pkg::*;
#(
   parameter int EXP_WIDTH  = 8,
   parameter int MANT_WIDTH = 23,
   parameter int IN_WIDTH   = MANT_WIDTH + 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_sign,
   input  logic [EXP_WIDTH+1:0]  in_exp,
   input  logic [IN_WIDTH-1:0]   in_mant,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_sign,
   output logic [EXP_WIDTH-1:0]  out_exp,
   output logic [MANT_WIDTH-1:0] out_mant,
   output logic [2:0]            out_flags
);

   localparam int EW2 = EXP_WIDTH + 2;
   localparam int PW  = $clog2(IN_WIDTH);
   localparam int MW1 = MANT_WIDTH + 1;
   localparam int N   = IN_WIDTH - 2;
   localparam int GRD = N - 1 - MANT_WIDTH;

   localparam logic [IN_WIDTH-1:0]   STICKY_MASK = (IN_WIDTH'(1) << GRD) - IN_WIDTH'(1);
   localparam logic [PW-1:0]         POS_N       = PW'(N);
   localparam logic [PW-1:0]         POS_TOP     = PW'(IN_WIDTH - 1);
   localparam logic signed [EW2-1:0] EXP_LIMIT   = EW2'(fp_exp_limit(EXP_WIDTH));
   localparam logic signed [EW2-1:0] EXP_ZERO    = '0;

   logic                  w_s1_load;
   logic                  w_s2_load;
   logic [PW-1:0]         w_lod_pos;
   logic                  w_lod_has_one;

   logic                  r_s1_valid;
   logic                  r_s1_sign;
   logic signed [EW2-1:0] r_s1_exp;
   logic [IN_WIDTH-1:0]   r_s1_mant;
   logic [PW-1:0]         r_s1_pos;
   logic                  r_s1_zero;

   logic                  r_out_valid;
   logic                  r_out_sign;
   logic [EXP_WIDTH-1:0]  r_out_exp;
   logic [MANT_WIDTH-1:0] r_out_mant;
   fp_flags_t             r_out_flags;

   logic [PW-1:0]         w_lshift;
   logic [IN_WIDTH-1:0]   w_norm;
   logic                  w_shift_sticky;
   logic signed [EW2-1:0] w_exp_norm;
   logic signed [EW2-1:0] w_exp_final;
   logic [MANT_WIDTH-1:0] w_frac;
   logic                  w_guard;
   logic                  w_sticky;
   logic                  w_round_up;
   logic [MANT_WIDTH:0]   w_frac_rnd;
   logic [EXP_WIDTH-1:0]  w_exp_pack;
   logic [MANT_WIDTH-1:0] w_mant_pack;
   fp_flags_t             w_flags;
   logic                  w_unused;

   // A stage may load when its downstream slot is empty or draining this cycle.
   assign w_s2_load = !r_out_valid || out_ready;
   assign w_s1_load = !r_s1_valid || w_s2_load;
   assign in_ready  = w_s1_load;

   leading_one_detector #(
      .WIDTH (IN_WIDTH)
   ) u_lod (
      .i_vec     (in_mant),
      .o_pos     (w_lod_pos),
      .o_has_one (w_lod_has_one)
   );

   // Stage 1: capture the raw result together with its leading-one position.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_sign  <= 1'b0;
         r_s1_exp   <= '0;
         r_s1_mant  <= '0;
         r_s1_pos   <= '0;
         r_s1_zero  <= 1'b1;
      end else if (w_s1_load) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_sign <= in_sign;
            r_s1_exp  <= in_exp;
            r_s1_mant <= in_mant;
            r_s1_pos  <= w_lod_pos;
            r_s1_zero <= !w_lod_has_one;
         end
      end
   end

   // Stage 2 datapath: normalize to the hidden-bit position, round, classify.
   always_comb begin
      w_lshift       = '0;
      w_norm         = r_s1_mant;
      w_shift_sticky = 1'b0;
      w_exp_norm     = r_s1_exp;
      if (r_s1_pos == POS_TOP) begin
         // Carry into the top bit: one right shift, dropped bit joins sticky.
         w_norm         = r_s1_mant >> 1;
         w_shift_sticky = r_s1_mant[0];
         w_exp_norm     = r_s1_exp + EW2'(1);
      end else begin
         w_lshift   = POS_N - r_s1_pos;
         w_norm     = r_s1_mant << w_lshift;
         w_exp_norm = r_s1_exp - EW2'(w_lshift);
      end

      w_frac      = w_norm[N-1 -: MANT_WIDTH];
      w_guard     = w_norm[GRD];
      w_sticky    = (|(w_norm & STICKY_MASK)) | w_shift_sticky;
      w_round_up  = w_guard && (w_sticky || w_frac[0]);
      w_frac_rnd  = {1'b0, w_frac} + MW1'(w_round_up);
      // An all-ones fraction rounding up wraps to zero and bumps the exponent.
      w_exp_final = w_exp_norm + EW2'(w_frac_rnd[MANT_WIDTH]);

      w_exp_pack  = '0;
      w_mant_pack = '0;
      w_flags     = '0;
      if (r_s1_zero) begin
         w_flags = '0;
      end else if (w_exp_final >= EXP_LIMIT) begin
         w_exp_pack  = '1;
         w_flags.ovf = 1'b1;
         w_flags.inx = 1'b1;
      end else if (w_exp_final <= EXP_ZERO) begin
         // No subnormal support: anything below the normal range flushes.
         w_flags.udf = 1'b1;
         w_flags.inx = 1'b1;
      end else begin
         w_exp_pack  = w_exp_final[EXP_WIDTH-1:0];
         w_mant_pack = w_frac_rnd[MANT_WIDTH-1:0];
         w_flags.inx = w_guard || w_sticky;
      end
   end

   // The leading one and the bit above it are implied after normalization.
   assign w_unused = &{1'b0, w_norm[IN_WIDTH-1:N]};

   // Stage 2 output register: holds while the downstream stalls.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_sign  <= 1'b0;
         r_out_exp   <= '0;
         r_out_mant  <= '0;
         r_out_flags <= '0;
      end else if (w_s2_load) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out_sign  <= r_s1_sign;
            r_out_exp   <= w_exp_pack;
            r_out_mant  <= w_mant_pack;
            r_out_flags <= w_flags;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_sign  = r_out_sign;
   assign out_exp   = r_out_exp;
   assign out_mant  = r_out_mant;
   assign out_flags = r_out_flags;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Self-checking bench for fp_normalize_round at default parameters.
module tb_fp_normalize_round;
   import fp_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_sign = 1'b0;
   logic [9:0]  in_exp = '0;
   logic [26:0] in_mant = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        out_sign;
   logic [7:0]  out_exp;
   logic [22:0] out_mant;
   logic [2:0]  out_flags;

   typedef struct {
      logic        s;
      logic [7:0]  e;
      logic [22:0] m;
      logic [2:0]  f;
   } res_t;

   res_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_in  = 0;
   int   n_out = 0;
   logic have_hold = 1'b0;
   res_t held;

   fp_normalize_round dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sign   (in_sign),
      .in_exp    (in_exp),
      .in_mant   (in_mant),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sign  (out_sign),
      .out_exp   (out_exp),
      .out_mant  (out_mant),
      .out_flags (out_flags)
   );

   always #5 clk = ~clk;

   // Value = m / 2^25 * 2^(e-127); round the 24-bit significand by remainder compare.
   function automatic res_t model(input logic s, input logic [9:0] e, input logic [26:0] m);
      res_t   r;
      longint mm, p, sh, q0, rem, half, ex;
      logic   inx;
      r.s = s; r.e = '0; r.m = '0; r.f = '0;
      mm = longint'(m);
      if (mm == 0) return r;
      p   = longint'($clog2(mm + 1)) - 1;
      sh  = p - 23;
      inx = 1'b0;
      if (sh > 0) begin
         q0   = mm >> sh;
         rem  = mm - (q0 << sh);
         half = longint'(1) << (sh - 1);
         inx  = (rem != 0);
         if (rem > half || (rem == half && q0[0])) q0 = q0 + 1;
      end else begin
         q0 = mm << (-sh);
      end
      ex = longint'($signed(e)) + (p - 25);
      if (q0 == (longint'(1) << 24)) begin
         q0 = q0 >> 1;
         ex = ex + 1;
      end
      if (ex >= 255) begin
         r.e = 8'hFF;
         r.f[FLAG_OVF] = 1'b1;
         r.f[FLAG_INX] = 1'b1;
      end else if (ex <= 0) begin
         r.f[FLAG_UDF] = 1'b1;
         r.f[FLAG_INX] = 1'b1;
      end else begin
         r.e = ex[7:0];
         r.m = q0[22:0];
         r.f[FLAG_INX] = inx;
      end
      return r;
   endfunction

   task automatic cmp(input string name, input res_t got, input res_t want);
      n_cmp++;
      if (got.s !== want.s || got.e !== want.e || got.m !== want.m || got.f !== want.f) begin
         n_bad++;
         $display("FAIL %s: got s=%0d e=%0h m=%0h f=%b, want s=%0d e=%0h m=%0h f=%b",
                  name, got.s, got.e, got.m, got.f, want.s, want.e, want.m, want.f);
      end
   endtask

   task automatic chk(input string name, input longint got, input longint want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   // Scoreboard and output monitor, sampled mid-cycle.
   always @(negedge clk) begin
      res_t cur;
      cur.s = out_sign; cur.e = out_exp; cur.m = out_mant; cur.f = out_flags;
      if (!rst_n) begin
         q.delete();
         have_hold = 1'b0;
      end else begin
         if (have_hold) cmp("hold_stable", cur, held);
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_beat", 1, 0);
            end else if (out_ready) begin
               cmp("beat", cur, q.pop_front());
               n_out++;
            end
         end
         have_hold = out_valid && !out_ready;
         held = cur;
         if (in_valid && in_ready) begin
            q.push_back(model(in_sign, in_exp, in_mant));
            n_in++;
         end
      end
   end

   task automatic send(input logic s, input logic [9:0] e, input logic [26:0] m);
      in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            return;
         end
      end
      chk("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   // Pin the model to a hand-computed result, then push the vector through the DUT.
   task automatic pin(input string name, input logic s, input logic [9:0] e, input logic [26:0] m,
                      input logic [7:0] we, input logic [22:0] wm, input logic [2:0] wf);
      res_t w;
      w.s = s; w.e = we; w.m = wm; w.f = wf;
      cmp(name, model(s, e, m), w);
      send(s, e, m);
   endtask

   task automatic drain(input string name);
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (q.size() == 0 && !out_valid) break;
      end
      chk(name, q.size(), 0);
   endtask

   initial begin
      int base;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_word", {out_sign, out_exp, out_mant, out_flags}, 0);
      @(posedge clk); #1;

      // Directed vectors, streamed back to back.
      pin("one",        1'b0, 10'd127, 27'h2000000, 8'd127, 23'h0,      3'b000);
      pin("rshift",     1'b0, 10'd127, 27'h4000000, 8'd128, 23'h0,      3'b000);
      pin("lshift",     1'b0, 10'd127, 27'h0000008, 8'd105, 23'h0,      3'b000);
      pin("tie_even",   1'b0, 10'd127, 27'h2000002, 8'd127, 23'h0,      3'b001);
      pin("tie_odd",    1'b1, 10'd127, 27'h2000006, 8'd127, 23'h2,      3'b001);
      pin("carry_ovf",  1'b0, 10'd254, 27'h3FFFFFE, 8'hFF,  23'h0,      3'b101);
      pin("udf",        1'b0, 10'd10,  27'h0000001, 8'd0,   23'h0,      3'b011);
      pin("zero_neg",   1'b1, 10'd50,  27'h0000000, 8'd0,   23'h0,      3'b000);
      pin("carry_norm", 1'b0, 10'd100, 27'h3FFFFFF, 8'd101, 23'h0,      3'b001);
      pin("sticky_dn",  1'b1, 10'd200, 27'h2800001, 8'd200, 23'h200000, 3'b001);
      pin("ovf_edge",   1'b0, 10'd255, 27'h2000000, 8'hFF,  23'h0,      3'b101);
      pin("max_norm",   1'b0, 10'd253, 27'h4000000, 8'd254, 23'h0,      3'b000);
      pin("min_norm",   1'b0, 10'd1,   27'h2000000, 8'd1,   23'h0,      3'b000);
      pin("udf_edge",   1'b1, 10'd0,   27'h2000000, 8'd0,   23'h0,      3'b011);
      pin("neg_exp",    1'b0, 10'h3FB, 27'h4000000, 8'd0,   23'h0,      3'b011);
      send(1'b0, 10'd140, 27'h1234567);
      send(1'b1, 10'd90,  27'h5555555);
      send(1'b0, 10'd127, 27'h0FFFFFF);
      drain("drain_directed");
      chk("count_directed", n_out, n_in);

      // Backpressure: only two beats fit while the output is stalled.
      @(posedge clk); #1;
      out_ready = 1'b0;
      base = n_in;
      fork
         begin
            send(1'b0, 10'd127, 27'h2000001);
            send(1'b1, 10'd128, 27'h2000003);
            send(1'b0, 10'd129, 27'h3000000);
            send(1'b1, 10'd130, 27'h2000007);
         end
      join_none
      repeat (6) @(negedge clk);
      chk("bp_accepted", n_in - base, 2);
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait fork;
      drain("drain_bp");
      chk("bp_all_out", n_out, n_in);
      chk("bp_four_in", n_in - base, 4);

      // Reset mid-stream discards in-flight beats.
      @(posedge clk); #1;
      in_valid = 1'b1; in_sign = 1'b0; in_exp = 10'd127; in_mant = 27'h2000000;
      @(posedge clk); #1 in_mant = 27'h2400000;
      @(posedge clk); #1 in_mant = 27'h2800000;
      @(posedge clk); #1;
      rst_n = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      base = n_out;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("rst_no_stale", out_valid, 0);
      end
      chk("rst_no_pop", n_out - base, 0);

      // Pipeline still works after the mid-stream reset.
      @(posedge clk); #1;
      send(1'b0, 10'd127, 27'h2000006);
      drain("drain_post_rst");
      chk("post_rst_out", n_out - base, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time budget");
      $fatal(1);
   end

endmodule
